alu_control_muldiv: RTL

Parametrised successor to the combinational ALU-operation decoder. It decodes ALUOp/Funct3/Funct7 into a 4-bit ALU operation for single-cycle ops, with explicit I-type handling. It also executes RV32M/RV64M multiply/divide ops on an iterative multi-cycle datapath with a valid/ready/done handshake. It sits in the EX stage beside the ALU and drives the pipeline stall and the EX result mux.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_control_muldiv_if.sv | 30 +++
 rtl/md_iter_core.sv | 78 +++++++
 rtl/alu_control_muldiv.sv | 135 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU decoder and the M-extension unit.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_XOR  = 4'b0011,
      ALU_SLL  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_SUB  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_EQ   = 4'b1000,
      ALU_SLT  = 4'b1100,
      ALU_SLTU = 4'b1101
   } alu_op_t;

   localparam logic [1:0] ALUOP_MEM    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_ARITH  = 2'b10;
   localparam logic [1:0] ALUOP_JUMP   = 2'b11;

   localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   typedef enum logic [2:0] {
      MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
      MD_DIV, MD_DIVU, MD_REM, MD_REMU
   } md_op_t;

endpackage

// File: rtl/alu_control_muldiv_if.sv
// Decode fields, operands and mul/div handshake between EX stage and the control unit.
interface alu_control_muldiv_if #(parameter int XLEN = 32);
   import alu_pkg::*;

   logic [1:0]      ALUOp;
   logic [6:0]      Funct7;
   logic [2:0]      Funct3;
   logic            IsImm;
   logic            valid_i;
   logic            kill_i;
   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_b;
   alu_op_t         Operation;
   logic            is_md_o;
   logic            ready_o;
   logic            busy_o;
   logic            done_o;
   logic [XLEN-1:0] result_o;

   modport master (
      output ALUOp, Funct7, Funct3, IsImm, valid_i, kill_i, src_a, src_b,
      input  Operation, is_md_o, ready_o, busy_o, done_o, result_o
   );

   modport slave (
      input  ALUOp, Funct7, Funct3, IsImm, valid_i, kill_i, src_a, src_b,
      output Operation, is_md_o, ready_o, busy_o, done_o, result_o
   );

endinterface

// File: rtl/md_iter_core.sv
// Unsigned iterative core: shift-add multiply or restoring divide, one bit per cycle.
// res_hi/res_lo show the post-step value so the caller can register the result on `last`.
module md_iter_core #(
   parameter int XLEN    = 32,
   parameter int LATENCY = XLEN
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            kill,
   input  logic            is_div,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            last,
   output logic [XLEN-1:0] res_hi,
   output logic [XLEN-1:0] res_lo
);

   localparam int CW = $clog2(LATENCY + 1);

   logic            run;
   logic            div_q;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] hi, lo, b_q;
   logic [XLEN:0]   sum, shifted, diff;
   logic            step;
   logic [XLEN-1:0] hi_n, lo_n;

   // Mul: {hi,lo} = partial product / remaining multiplier. Div: hi = remainder, lo = dividend/quotient.
   always_comb begin
      sum     = {1'b0, hi} + {1'b0, b_q};
      shifted = {hi, lo[XLEN-1]};
      diff    = shifted - {1'b0, b_q};
      step    = run && (32'(cnt) < XLEN);
      hi_n    = hi;
      lo_n    = lo;
      if (step) begin
         if (div_q) begin
            hi_n = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], ~diff[XLEN]};
         end else begin
            hi_n = lo[0] ? sum[XLEN:1] : {1'b0, hi[XLEN-1:1]};
            lo_n = {(lo[0] ? sum[0] : hi[0]), lo[XLEN-1:1]};
         end
      end
   end

   assign last   = run && (cnt == CW'(LATENCY - 1));
   assign res_hi = hi_n;
   assign res_lo = lo_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         run   <= 1'b0;
         div_q <= 1'b0;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
         b_q   <= '0;
      end else if (kill) begin
         run <= 1'b0;
         cnt <= '0;
      end else if (start) begin
         run   <= 1'b1;
         cnt   <= '0;
         hi    <= '0;
         lo    <= op_a;
         b_q   <= op_b;
         div_q <= is_div;
      end else if (run) begin
         hi  <= hi_n;
         lo  <= lo_n;
         cnt <= cnt + 1'b1;
         if (last) run <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_control_muldiv.sv
// ALU operation decoder plus multi-cycle RV32M/RV64M unit with valid/ready/done handshake.
// MD_LATENCY must be >= XLEN; extra cycles beyond XLEN just hold the finished value.
module alu_control_muldiv
   import alu_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int MD_LATENCY = XLEN
) (
   input logic                  clk,
   input logic                  reset,
   alu_control_muldiv_if.slave  bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]      state;
   logic            is_md;
   logic            accept;
   alu_op_t         op_dec;
   md_op_t          md_op;
   logic            sign_a, sign_b, a_neg, b_neg, neg_n, hi_sel_n;
   logic [XLEN-1:0] mag_a, mag_b;
   logic            div_q, hi_sel_q, neg_q;
   logic            core_last;
   logic [XLEN-1:0] core_hi, core_lo;
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0] qr, qr_s, md_res;
   logic [XLEN-1:0] result_q;

   assign is_md = (bus.ALUOp == ALUOP_ARITH) && !bus.IsImm && (bus.Funct7 == FUNCT7_MULDIV);

   always_comb begin
      op_dec = ALU_ADD;
      case (bus.ALUOp)
         ALUOP_BRANCH: begin
            case (bus.Funct3[2:1])
               2'b10:   op_dec = ALU_SLT;
               2'b11:   op_dec = ALU_SLTU;
               default: op_dec = ALU_EQ;
            endcase
         end
         ALUOP_ARITH: begin
            if (!is_md) begin
               case (bus.Funct3)
                  3'b000:  op_dec = (!bus.IsImm && bus.Funct7 == FUNCT7_ALT) ? ALU_SUB : ALU_ADD;
                  3'b001:  op_dec = ALU_SLL;
                  3'b010:  op_dec = ALU_SLT;
                  3'b011:  op_dec = ALU_SLTU;
                  3'b100:  op_dec = ALU_XOR;
                  3'b101:  op_dec = bus.Funct7[5] ? ALU_SRA : ALU_SRL;
                  3'b110:  op_dec = ALU_OR;
                  default: op_dec = ALU_AND;
               endcase
            end
         end
         default: op_dec = ALU_ADD;
      endcase
   end

   // Operands go to the core as magnitudes; the sign is restored on the way out.
   always_comb begin
      md_op    = md_op_t'(bus.Funct3);
      sign_a   = (md_op == MD_MULH) || (md_op == MD_MULHSU) || (md_op == MD_DIV) || (md_op == MD_REM);
      sign_b   = (md_op == MD_MULH) || (md_op == MD_DIV) || (md_op == MD_REM);
      a_neg    = sign_a && bus.src_a[XLEN-1];
      b_neg    = sign_b && bus.src_b[XLEN-1];
      mag_a    = a_neg ? (~bus.src_a + 1'b1) : bus.src_a;
      mag_b    = b_neg ? (~bus.src_b + 1'b1) : bus.src_b;
      hi_sel_n = md_op[2] ? md_op[1] : (md_op[1:0] != 2'b00);
      case (md_op)
         MD_DIV:          neg_n = (a_neg ^ b_neg) && (bus.src_b != '0);
         MD_REM:          neg_n = a_neg;
         MD_DIVU, MD_REMU: neg_n = 1'b0;
         default:         neg_n = a_neg ^ b_neg;
      endcase
   end

   assign accept = bus.valid_i && is_md && (state != S_RUN) && !bus.kill_i;

   md_iter_core #(.XLEN(XLEN), .LATENCY(MD_LATENCY)) u_core (
      .clk    (clk),
      .reset  (reset),
      .start  (accept),
      .kill   (bus.kill_i),
      .is_div (md_op[2]),
      .op_a   (mag_a),
      .op_b   (mag_b),
      .last   (core_last),
      .res_hi (core_hi),
      .res_lo (core_lo)
   );

   // Div-by-zero and signed overflow fall out of the magnitude core without special paths.
   always_comb begin
      prod   = {core_hi, core_lo};
      prod_s = neg_q ? (~prod + 1'b1) : prod;
      qr     = hi_sel_q ? core_hi : core_lo;
      qr_s   = neg_q ? (~qr + 1'b1) : qr;
      md_res = div_q ? qr_s : (hi_sel_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         result_q <= '0;
         div_q    <= 1'b0;
         hi_sel_q <= 1'b0;
         neg_q    <= 1'b0;
      end else if (bus.kill_i) begin
         state <= S_IDLE;
      end else if (accept) begin
         state    <= S_RUN;
         div_q    <= md_op[2];
         hi_sel_q <= hi_sel_n;
         neg_q    <= neg_n;
      end else if (state == S_RUN) begin
         if (core_last) begin
            state    <= S_DONE;
            result_q <= md_res;
         end
      end else if (state == S_DONE) begin
         state <= S_IDLE;
      end
   end

   assign bus.Operation = op_dec;
   assign bus.is_md_o   = is_md;
   assign bus.ready_o   = (state != S_RUN);
   assign bus.busy_o    = (state == S_RUN);
   assign bus.done_o    = (state == S_DONE);
   assign bus.result_o  = result_q;

endmodule
